// File: rtl/weight_store_pkg.sv
// Shared constants, index helpers and the update-stage record for the weight store.
package weight_store_pkg;

  localparam int DATA_W_DEF   = 48;
  localparam int LAYERS_DEF   = 4;
  localparam int ROWS_DEF     = 16;
  localparam int LR_SHIFT_DEF = 4;
  // Gradient field is sized for the widest supported DATA_W; users take the low DATA_W bits.
  localparam int GRAD_MAX_W   = 64;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           idx;
    logic [GRAD_MAX_W-1:0] grad;
  } upd_stage_t;

  function automatic logic [31:0] flat_index(input logic [31:0] layer,
                                             input logic [31:0] row,
                                             input int unsigned rows);
    return 32'(layer * rows + row);
  endfunction

  function automatic logic in_range(input logic [31:0] layer,
                                    input logic [31:0] row,
                                    input int unsigned layers,
                                    input int unsigned rows);
    return (layer < layers) && (row < rows);
  endfunction

endpackage

// File: rtl/weight_store_rmw_if.sv
// Host-side bus of the weight store: load writes, gradient updates, reads and status.
interface weight_store_rmw_if #(parameter int DATA_W = 48);

  logic                     is_write;
  logic [31:0]              write_layer_index;
  logic [31:0]              write_row_index;
  logic signed [DATA_W-1:0] write_data;
  logic                     is_update;
  logic [31:0]              update_layer_index;
  logic [31:0]              update_row_index;
  logic signed [DATA_W-1:0] dc_dw;
  logic                     rd_en;
  logic [31:0]              rd_layer_index;
  logic [31:0]              rd_row_index;
  logic                     rd_valid;
  logic signed [DATA_W-1:0] rd_data;
  logic                     upd_pending;
  logic                     sat_pulse;
  logic                     addr_err;
  logic                     clear_err;
  logic [31:0]              upd_count;

  modport master (
    output is_write, write_layer_index, write_row_index, write_data,
           is_update, update_layer_index, update_row_index, dc_dw,
           rd_en, rd_layer_index, rd_row_index, clear_err,
    input  rd_valid, rd_data, upd_pending, sat_pulse, addr_err, upd_count
  );

  modport slave (
    input  is_write, write_layer_index, write_row_index, write_data,
           is_update, update_layer_index, update_row_index, dc_dw,
           rd_en, rd_layer_index, rd_row_index, clear_err,
    output rd_valid, rd_data, upd_pending, sat_pulse, addr_err, upd_count
  );

endinterface

// File: rtl/weight_update_alu.sv
// Gradient step w - (g >>> LR_SHIFT) computed one bit wide and clamped to the signed range.
module weight_update_alu #(
  parameter int DATA_W   = 48,
  parameter int LR_SHIFT = 4
) (
  input  logic signed [DATA_W-1:0] old_w,
  input  logic signed [DATA_W-1:0] grad,
  output logic signed [DATA_W-1:0] new_w,
  output logic                     sat
);

  localparam logic signed [DATA_W-1:0] W_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] W_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] step_s;
  logic signed [DATA_W:0]   diff_s;

  // Arithmetic shift floors toward -inf; overflow shows as the two top bits disagreeing
  always_comb begin
    step_s = grad >>> LR_SHIFT;
    diff_s = (DATA_W+1)'(old_w) - (DATA_W+1)'(step_s);
    sat    = (diff_s[DATA_W] != diff_s[DATA_W-1]);
    if (!sat) begin
      new_w = diff_s[DATA_W-1:0];
    end else if (diff_s[DATA_W]) begin
      new_w = W_MIN;
    end else begin
      new_w = W_MAX;
    end
  end

endmodule

// File: rtl/weight_store_rmw.sv
// Flop-based LAYERS x ROWS weight array with load writes, forwarded reads and a
// two-stage saturating gradient update (U0 latch, U1 read-modify-write).
module weight_store_rmw
  import weight_store_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LAYERS   = LAYERS_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int LR_SHIFT = LR_SHIFT_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  weight_store_rmw_if.slave bus
);

  localparam int ENTRIES = LAYERS * ROWS;

  logic signed [DATA_W-1:0] mem_r [ENTRIES];
  upd_stage_t               upd_r;
  logic                     rd_valid_r;
  logic signed [DATA_W-1:0] rd_data_r;
  logic                     sat_pulse_r;
  logic                     addr_err_r;
  logic [31:0]              upd_count_r;

  logic                     wr_ok_s, upd_ok_s, rd_ok_s, err_s;
  logic                     collide_s, commit_s, sat_s;
  logic [31:0]              wr_idx_s, upd_idx_s, rd_idx_s;
  logic signed [DATA_W-1:0] old_w_s, new_w_s, rd_next_s;

  // Address decode and range checks for the three strobed ports
  always_comb begin
    wr_idx_s  = flat_index(bus.write_layer_index, bus.write_row_index, ROWS);
    upd_idx_s = flat_index(bus.update_layer_index, bus.update_row_index, ROWS);
    rd_idx_s  = flat_index(bus.rd_layer_index, bus.rd_row_index, ROWS);
    wr_ok_s   = bus.is_write  && in_range(bus.write_layer_index, bus.write_row_index, LAYERS, ROWS);
    upd_ok_s  = bus.is_update && in_range(bus.update_layer_index, bus.update_row_index, LAYERS, ROWS);
    rd_ok_s   = bus.rd_en     && in_range(bus.rd_layer_index, bus.rd_row_index, LAYERS, ROWS);
    err_s     = (bus.is_write && !wr_ok_s) || (bus.is_update && !upd_ok_s) || (bus.rd_en && !rd_ok_s);
  end

  // U1 operand fetch; a same-entry load write in this cycle cancels the commit
  always_comb begin
    old_w_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      old_w_s = (upd_r.idx == 32'(i)) ? mem_r[i] : old_w_s;
    end
    collide_s = wr_ok_s && (wr_idx_s == upd_r.idx);
    commit_s  = upd_r.valid && !collide_s;
  end

  weight_update_alu #(.DATA_W(DATA_W), .LR_SHIFT(LR_SHIFT)) u_alu (
    .old_w (old_w_s),
    .grad  (signed'(upd_r.grad[DATA_W-1:0])),
    .new_w (new_w_s),
    .sat   (sat_s)
  );

  // Read value as of the end of this cycle, with both commits forwarded
  always_comb begin
    rd_next_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rd_next_s = (rd_idx_s == 32'(i)) ? mem_r[i] : rd_next_s;
    end
    if (wr_ok_s && (wr_idx_s == rd_idx_s)) begin
      rd_next_s = bus.write_data;
    end else if (commit_s && (upd_r.idx == rd_idx_s)) begin
      rd_next_s = new_w_s;
    end else begin
      rd_next_s = rd_next_s;
    end
  end

  // Weight array: load write has priority over the update commit
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < ENTRIES; i++) mem_r[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_ok_s && (wr_idx_s == 32'(i))) begin
          mem_r[i] <= bus.write_data;
        end else if (commit_s && (upd_r.idx == 32'(i))) begin
          mem_r[i] <= new_w_s;
        end
      end
    end
  end

  // U0 stage register: latch a valid update request
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      upd_r <= '0;
    end else begin
      upd_r.valid <= upd_ok_s;
      upd_r.idx   <= upd_idx_s;
      upd_r.grad  <= GRAD_MAX_W'(bus.dc_dw);
    end
  end

  // Registered read port, saturation pulse, commit counter and sticky error
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_valid_r  <= 1'b0;
      rd_data_r   <= '0;
      sat_pulse_r <= 1'b0;
      upd_count_r <= 32'd0;
      addr_err_r  <= 1'b0;
    end else begin
      rd_valid_r  <= rd_ok_s;
      if (rd_ok_s) rd_data_r <= rd_next_s;
      sat_pulse_r <= commit_s && sat_s;
      upd_count_r <= upd_count_r + {31'd0, commit_s};
      if (err_s) begin
        addr_err_r <= 1'b1;
      end else if (bus.clear_err) begin
        addr_err_r <= 1'b0;
      end
    end
  end

  assign bus.rd_valid    = rd_valid_r;
  assign bus.rd_data     = rd_data_r;
  assign bus.upd_pending = upd_r.valid;
  assign bus.sat_pulse   = sat_pulse_r;
  assign bus.addr_err    = addr_err_r;
  assign bus.upd_count   = upd_count_r;

endmodule
